// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          ifu_valid;
    logic [AW-1:0] ifu_addr;
    logic          ifu_ready;
    logic          ifu_rvalid;
    logic [DW-1:0] ifu_rdata;

    logic          lsu_valid;
    logic [AW-1:0] lsu_addr;
    logic          lsu_wen;
    logic [DW-1:0] lsu_wdata;
    logic [2:0]    lsu_memop;
    logic          lsu_ready;
    logic          lsu_rvalid;
    logic [DW-1:0] lsu_rdata;

    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_memop;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          err;

    modport master (
        input  ifu_valid, ifu_addr,
        output ifu_ready, ifu_rvalid, ifu_rdata,
        input  lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_memop,
        output lsu_ready, lsu_rvalid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_memop,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output err
    );

    modport slave (
        output ifu_valid, ifu_addr,
        input  ifu_ready, ifu_rvalid, ifu_rdata,
        output lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_memop,
        input  lsu_ready, lsu_rvalid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_memop,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: one transaction in flight,
// fixed LSU-first priority, response timeout forcing an error reply.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int unsigned CW         = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0] MEMOP_WORD  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic          owner;  // 1 = LSU, 0 = IFU
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic          wen_q;
    logic [DW-1:0] wdata_q;
    logic [2:0]    memop_q;
    logic          ifu_rvalid_q;
    logic          lsu_rvalid_q;
    logic          err_q;
    logic [DW-1:0] ifu_rdata_q;
    logic [DW-1:0] lsu_rdata_q;
    logic          grant_lsu;
    logic          grant_ifu;

    // Grants are combinational so ready pulses in the accepting IDLE cycle
    assign grant_lsu = !rst && (state == IDLE) && bus.lsu_valid;
    assign grant_ifu = !rst && (state == IDLE) && !bus.lsu_valid && bus.ifu_valid;

    assign bus.ifu_ready     = grant_ifu;
    assign bus.lsu_ready     = grant_lsu;
    assign bus.mem_req_valid = (state == REQ);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_memop     = memop_q;
    assign bus.ifu_rvalid    = ifu_rvalid_q;
    assign bus.ifu_rdata     = ifu_rdata_q;
    assign bus.lsu_rvalid    = lsu_rvalid_q;
    assign bus.lsu_rdata     = lsu_rdata_q;
    assign bus.err           = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            cnt          <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            memop_q      <= '0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        owner   <= 1'b1;
                        addr_q  <= bus.lsu_addr;
                        wen_q   <= bus.lsu_wen;
                        wdata_q <= bus.lsu_wdata;
                        memop_q <= bus.lsu_memop;
                        state   <= REQ;
                    end else if (grant_ifu) begin
                        owner   <= 1'b0;
                        addr_q  <= bus.ifu_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        memop_q <= MEMOP_WORD;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        cnt   <= '0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    cnt <= cnt + CW'(1);
                    // A real response beats a timeout landing on the same cycle
                    if (bus.mem_resp_valid) begin
                        if (owner) begin
                            lsu_rvalid_q <= 1'b1;
                            lsu_rdata_q  <= bus.mem_resp_data;
                        end else begin
                            ifu_rvalid_q <= 1'b1;
                            ifu_rdata_q  <= bus.mem_resp_data;
                        end
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        if (owner) begin
                            lsu_rvalid_q <= 1'b1;
                            lsu_rdata_q  <= '0;
                        end else begin
                            ifu_rvalid_q <= 1'b1;
                            ifu_rdata_q  <= '0;
                        end
                        err_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a grant-order scoreboard
// fed by a memory model with configurable or random latency.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [2:0]  memop;
    } gnt_t;
    typedef struct {
        logic [31:0] data;
        bit          err;
    } rsp_t;

    gnt_t grant_q[$];
    rsp_t resp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rv_count = 0;

    logic mem_auto, rand_lat;
    int   req_lat, resp_lat;
    logic a_ready, a_rvalid, m_ready, m_rvalid;
    logic [31:0] a_data, m_data;

    assign bus.mem_req_ready  = mem_auto ? a_ready  : m_ready;
    assign bus.mem_resp_valid = mem_auto ? a_rvalid : m_rvalid;
    assign bus.mem_resp_data  = mem_auto ? a_data   : m_data;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    // Scoreboard: grants pushed on ready, popped on rvalid
    task automatic monitor();
        logic [31:0] last_i, last_l, got;
        gnt_t g;
        rsp_t r;
        last_i = '0;
        last_l = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                grant_q.delete();
                resp_q.delete();
                last_i = '0;
                last_l = '0;
            end else begin
                if (bus.ifu_rvalid || bus.lsu_rvalid || bus.err) begin
                    checks++;
                    if (bus.ifu_rvalid && bus.lsu_rvalid) begin
                        errors++;
                        $display("FAIL rvalid_exclusive: both rvalid high at %0t", $time);
                    end else if (!bus.ifu_rvalid && !bus.lsu_rvalid) begin
                        errors++;
                        $display("FAIL err_alone: err=1 without rvalid at %0t", $time);
                    end else if (grant_q.size() == 0 || resp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rvalid_unexpected: rvalid with no outstanding grant at %0t", $time);
                    end else begin
                        g = grant_q.pop_front();
                        r = resp_q.pop_front();
                        rv_count++;
                        got = bus.lsu_rvalid ? bus.lsu_rdata : bus.ifu_rdata;
                        if ({bus.lsu_rvalid, got, bus.err} !== {g.lsu, r.data, r.err}) begin
                            errors++;
                            $display("FAIL rvalid_route: got lsu=%0b data=%h err=%b, expected lsu=%0b data=%h err=%b at %0t",
                                     bus.lsu_rvalid, got, bus.err, g.lsu, r.data, r.err, $time);
                        end
                    end
                end
                checks++;
                if ((bus.ifu_ready && bus.lsu_ready) ||
                    (!bus.ifu_rvalid && bus.ifu_rdata !== last_i) ||
                    (!bus.lsu_rvalid && bus.lsu_rdata !== last_l)) begin
                    errors++;
                    $display("FAIL cycle_invariant: readys=%b%b ifu_rdata=%h(was %h) lsu_rdata=%h(was %h) at %0t",
                             bus.ifu_ready, bus.lsu_ready, bus.ifu_rdata, last_i, bus.lsu_rdata, last_l, $time);
                end
                last_i = bus.ifu_rdata;
                last_l = bus.lsu_rdata;
                if (bus.lsu_ready)
                    grant_q.push_back('{1'b1, bus.lsu_addr, bus.lsu_wen, bus.lsu_wdata, bus.lsu_memop});
                else if (bus.ifu_ready)
                    grant_q.push_back('{1'b0, bus.ifu_addr, 1'b0, 32'h0, 3'b010});
            end
        end
    endtask

    // Memory model: ready after cur_req stall cycles, response cur_resp cycles into RESP
    task automatic mem_model();
        int wcnt = 0, rcnt = 0, phase = 0, cur_req = 0, cur_resp = 0;
        logic [31:0] acc = '0;
        gnt_t g;
        a_ready = 1'b0; a_rvalid = 1'b0; a_data = '0;
        forever begin
            @(posedge clk);
            #1;
            a_rvalid = 1'b0;
            if (rst || !mem_auto) begin
                phase = 0; wcnt = 0; a_ready = 1'b0;
            end else if (phase == 0) begin
                if (!bus.mem_req_valid) begin
                    a_ready = 1'b0;
                    wcnt = 0;
                    cur_req  = rand_lat ? int'($urandom_range(0, 3)) : req_lat;
                    cur_resp = rand_lat ? int'($urandom_range(0, 9)) : resp_lat;
                    if (rand_lat && $urandom_range(0, 3) == 0) begin
                        a_rvalid = 1'b1;
                        a_data = $urandom;
                    end
                end else if (wcnt == cur_req) begin
                    a_ready = 1'b1;
                    phase = 1;
                    rcnt = 0;
                    acc = bus.mem_addr;
                    checks++;
                    if (grant_q.size() != 1) begin
                        errors++;
                        $display("FAIL mem_issue: %0d outstanding grants, expected 1 at %0t", grant_q.size(), $time);
                    end else begin
                        g = grant_q[0];
                        if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_memop} !== {g.addr, g.wen, g.wdata, g.memop}) begin
                            errors++;
                            $display("FAIL mem_payload: got %h/%b/%h/%b expected %h/%b/%h/%b at %0t",
                                     bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_memop,
                                     g.addr, g.wen, g.wdata, g.memop, $time);
                        end
                    end
                end else begin
                    a_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                a_ready = 1'b0;
                if (rcnt == cur_resp) begin
                    a_rvalid = 1'b1;
                    a_data = mem_read(acc);
                    resp_q.push_back('{a_data, 1'b0});
                    phase = 0;
                end else if (rcnt == TO - 1) begin
                    resp_q.push_back('{32'h0, 1'b1});
                    phase = 0;
                end else begin
                    rcnt++;
                end
            end
        end
    endtask

    task automatic ifu_req(input logic [31:0] a);
        bit got = 0;
        @(posedge clk); #1;
        bus.ifu_valid = 1'b1;
        bus.ifu_addr = a;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.ifu_ready) begin got = 1; break; end
        end
        @(posedge clk); #1;
        bus.ifu_valid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL ifu_grant: ready=0 after 400 cycles, required 1"); end
    endtask

    task automatic lsu_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [2:0] op);
        bit got = 0;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b1;
        bus.lsu_addr = a; bus.lsu_wen = w; bus.lsu_wdata = d; bus.lsu_memop = op;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.lsu_ready) begin got = 1; break; end
        end
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL lsu_grant: ready=0 after 400 cycles, required 1"); end
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (grant_q.size() == 0) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL drain: %0d grants still outstanding, required 0", grant_q.size()); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ifu_valid = 1'b1; bus.lsu_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.ifu_ready, bus.ifu_rvalid, bus.ifu_rdata, bus.lsu_ready, bus.lsu_rvalid, bus.lsu_rdata,
             bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_memop, bus.err} !== '0) begin
            errors++; $display("FAIL reset_outputs: outputs nonzero while rst held, required all 0");
        end
        @(posedge clk); #1;
        bus.ifu_valid = 1'b0; bus.lsu_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ifu_ready, bus.ifu_rvalid, bus.lsu_ready, bus.lsu_rvalid, bus.mem_req_valid, bus.err} !== 6'b0) begin
            errors++; $display("FAIL reset_release: control outputs nonzero after reset, required 0");
        end
    endtask

    task automatic test_single_fetch();
        req_lat = 0; resp_lat = 0;
        @(posedge clk); #1;
        bus.ifu_valid = 1'b1; bus.ifu_addr = 32'h8000_0000;
        @(negedge clk);
        checks++;
        if ({bus.ifu_ready, bus.lsu_ready} !== 2'b10) begin
            errors++; $display("FAIL fetch_ready: ifu/lsu ready=%b%b, required 10", bus.ifu_ready, bus.lsu_ready);
        end
        @(posedge clk); #1;
        bus.ifu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_memop} !== {1'b1, 32'h8000_0000, 1'b0, 3'b010}) begin
            errors++; $display("FAIL fetch_req: valid=%b addr=%h wen=%b memop=%b, required 1 80000000 0 010",
                               bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_memop);
        end
        @(negedge clk);
        checks++;
        if (bus.ifu_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_early: ifu_rvalid=1 at cycle 2, required 0"); end
        @(negedge clk);
        checks++;
        if ({bus.ifu_rvalid, bus.ifu_rdata, bus.lsu_rvalid, bus.err} !== {1'b1, 32'h0010_0073, 1'b0, 1'b0}) begin
            errors++; $display("FAIL fetch_resp: rvalid=%b rdata=%h lsu_rvalid=%b err=%b, required 1 00100073 0 0",
                               bus.ifu_rvalid, bus.ifu_rdata, bus.lsu_rvalid, bus.err);
        end
        wait_drain();
    endtask

    task automatic test_priority();
        bit seen = 0;
        req_lat = 0; resp_lat = 0;
        @(posedge clk); #1;
        bus.ifu_valid = 1'b1; bus.ifu_addr = 32'h8000_0040;
        bus.lsu_valid = 1'b1; bus.lsu_addr = 32'h8000_1000; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = 32'h0; bus.lsu_memop = 3'b100;
        @(negedge clk);
        checks++;
        if ({bus.lsu_ready, bus.ifu_ready} !== 2'b10) begin
            errors++; $display("FAIL prio_grant: lsu/ifu ready=%b%b, required 10", bus.lsu_ready, bus.ifu_ready);
        end
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (bus.lsu_rvalid) begin seen = 1; break; end
        end
        checks++;
        if ({seen, bus.ifu_ready} !== 2'b11) begin
            errors++; $display("FAIL prio_regrant: lsu_rvalid seen=%0b ifu_ready=%b, required 1 1", seen, bus.ifu_ready);
        end
        @(posedge clk); #1;
        bus.ifu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_valid, bus.mem_addr, bus.mem_memop, bus.mem_wen} !== {1'b1, 32'h8000_0040, 3'b010, 1'b0}) begin
            errors++; $display("FAIL prio_ifu_req: valid=%b addr=%h memop=%b wen=%b, required 1 80000040 010 0",
                               bus.mem_req_valid, bus.mem_addr, bus.mem_memop, bus.mem_wen);
        end
        wait_drain();
    endtask

    task automatic test_store_stall();
        int reqs = 0, lrdy = 0, irdy = 0, rv_at = -1;
        bit stable = 1;
        req_lat = 4; resp_lat = 2;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b1; bus.lsu_addr = 32'h8000_2000; bus.lsu_wen = 1'b1;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_memop = 3'b010;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lrdy += int'(bus.lsu_ready);
            irdy += int'(bus.ifu_ready);
            if (bus.mem_req_valid) begin
                reqs++;
                if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_memop} !== {32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 3'b010})
                    stable = 0;
            end
            if (bus.lsu_rvalid) begin rv_at = c; break; end
            @(posedge clk); #1;
            if (c == 0) bus.lsu_valid = 1'b0;
        end
        checks++;
        if (reqs != 5) begin errors++; $display("FAIL stall_req_cycles: mem_req_valid high %0d cycles, required 5", reqs); end
        checks++;
        if (lrdy != 1 || irdy != 0) begin
            errors++; $display("FAIL stall_ready_pulses: lsu_ready=%0d ifu_ready=%0d, required 1 0", lrdy, irdy);
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL stall_payload: payload changed while stalled, required stable"); end
        checks++;
        if (rv_at != 9) begin errors++; $display("FAIL stall_latency: lsu_rvalid at cycle %0d, required 9", rv_at); end
        wait_drain();
    endtask

    task automatic test_timeout();
        int rv_at = -1;
        // No response: LSU load times out
        req_lat = 0; resp_lat = 100;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b1; bus.lsu_addr = 32'h8000_3000; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = 32'h0; bus.lsu_memop = 3'b010;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.lsu_rvalid) begin rv_at = c; break; end
            @(posedge clk); #1;
            if (c == 0) bus.lsu_valid = 1'b0;
        end
        checks++;
        if ({rv_at == 10, bus.lsu_rdata, bus.err} !== {1'b1, 32'h0, 1'b1}) begin
            errors++; $display("FAIL timeout_err: rvalid cycle=%0d rdata=%h err=%b, required 10 00000000 1",
                               rv_at, bus.lsu_rdata, bus.err);
        end
        wait_drain();
        // Response on the last RESP cycle beats the timeout
        rv_at = -1;
        resp_lat = TO - 1;
        @(posedge clk); #1;
        bus.ifu_valid = 1'b1; bus.ifu_addr = 32'h8000_0100;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ifu_rvalid) begin rv_at = c; break; end
            @(posedge clk); #1;
            if (c == 0) bus.ifu_valid = 1'b0;
        end
        checks++;
        if ({rv_at == 10, bus.ifu_rdata, bus.err} !== {1'b1, mem_read(32'h8000_0100), 1'b0}) begin
            errors++; $display("FAIL timeout_race: rvalid cycle=%0d rdata=%h err=%b, required 10 %h 0",
                               rv_at, bus.ifu_rdata, bus.err, mem_read(32'h8000_0100));
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0; m_data = '0;
        @(posedge clk); #1;
        bus.ifu_valid = 1'b1; bus.ifu_addr = 32'h8000_0200;
        @(negedge clk);
        checks++;
        if (bus.ifu_ready !== 1'b1) begin errors++; $display("FAIL rstmid_grant: ifu_ready=%b, required 1", bus.ifu_ready); end
        @(posedge clk); #1;
        bus.ifu_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_rvalid = 1'b1; m_data = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({bus.ifu_ready, bus.ifu_rvalid, bus.ifu_rdata, bus.lsu_ready, bus.lsu_rvalid, bus.lsu_rdata,
             bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_memop, bus.err} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: outputs nonzero after mid-RESP reset, required all 0");
        end
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.ifu_rvalid, bus.lsu_rvalid, bus.err, bus.mem_req_valid} !== 4'b0) begin
                errors++; $display("FAIL rstmid_quiet: rvalid=%b%b err=%b req=%b, required 0000",
                                   bus.ifu_rvalid, bus.lsu_rvalid, bus.err, bus.mem_req_valid);
            end
        end
        mem_auto = 1'b1; req_lat = 1; resp_lat = 1;
        rv_count = 0;
        ifu_req(32'h8000_0300);
        wait_drain();
        checks++;
        if (rv_count != 1) begin errors++; $display("FAIL rstmid_recover: %0d responses, required 1", rv_count); end
    endtask

    task automatic test_back_to_back();
        rand_lat = 1'b1;
        rv_count = 0;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    ifu_req($urandom);
                end
            end
            begin
                for (int j = 0; j < 50; j++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    lsu_req($urandom, 1'($urandom), $urandom, 3'($urandom));
                end
            end
        join
        wait_drain();
        checks++;
        if (rv_count != 100) begin errors++; $display("FAIL b2b_count: %0d responses, required 100", rv_count); end
        rand_lat = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_auto = 1'b1; rand_lat = 1'b0; req_lat = 0; resp_lat = 0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_data = '0;
        bus.ifu_valid = 1'b0; bus.ifu_addr = '0;
        bus.lsu_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = '0; bus.lsu_memop = '0;
        fork
            monitor();
            mem_model();
        join_none
        test_reset();
        test_single_fetch();
        test_priority();
        test_store_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
